// File: rtl/dram_pkg.sv
// Shared DRAM command encoding and bank-geometry constants for the address composer.
package dram_pkg;

  localparam int NUM_BANKS      = 16;
  localparam int BANK_IDX_BITS  = 4;
  localparam int DRAM_ADDR_BITS = 17;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5
  } cmd_e;

  function automatic logic [BANK_IDX_BITS-1:0] bank_idx(input logic [1:0] bg, input logic [1:0] ba);
    return {bg, ba};
  endfunction

endpackage

// File: rtl/bank_row_table.sv
// Per-bank open flag and active row; combinational read, single write/close per cycle.
module bank_row_table
  import dram_pkg::*;
#(
  parameter int ROW_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BANK_IDX_BITS-1:0] rd_idx_i,
  output logic                     rd_open_o,
  output logic [ROW_BITS-1:0]      rd_row_o,
  input  logic                     wr_en_i,
  input  logic [BANK_IDX_BITS-1:0] wr_idx_i,
  input  logic [ROW_BITS-1:0]      wr_row_i,
  input  logic                     close_en_i,
  input  logic [BANK_IDX_BITS-1:0] close_idx_i,
  input  logic                     close_all_i
);

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];
  logic [ROW_BITS-1:0]  row_d [NUM_BANKS];

  assign rd_open_o = open_q[rd_idx_i];
  assign rd_row_o  = row_q[rd_idx_i];

  // Close-all dominates; the decoder never asserts more than one port per cycle anyway.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (close_all_i) begin
      open_d = '0;
    end else if (close_en_i) begin
      open_d[close_idx_i] = 1'b0;
    end else if (wr_en_i) begin
      open_d[wr_idx_i] = 1'b1;
      row_d[wr_idx_i]  = wr_row_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/dram_addr_composer.sv
// Rebuilds {row,bg,ba,col} bus addresses from a multiplexed DRAM command stream,
// flagging protocol violations and counting them.
module dram_addr_composer
  import dram_pkg::*;
#(
  parameter int ROW_BITS   = 8,
  parameter int COL_BITS   = 4,
  parameter int PADDR_BITS = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd,
  input  logic [DRAM_ADDR_BITS-1:0] addr_in,
  input  logic [1:0]                bg_in,
  input  logic [1:0]                ba_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PADDR_BITS-1:0]     out_addr,
  output logic                      out_is_write,
  output logic                      err_pulse,
  output logic [7:0]                err_count
);

  if (PADDR_BITS < COL_BITS + BANK_IDX_BITS + ROW_BITS) begin : g_chk_paddr
    $error("PADDR_BITS too small for row+bank+col");
  end
  if (ROW_BITS + COL_BITS > DRAM_ADDR_BITS) begin : g_chk_row_col
    $error("ROW_BITS+COL_BITS exceeds DRAM address bus");
  end

  logic [BANK_IDX_BITS-1:0] bank;
  logic                     accept;
  logic                     tbl_open;
  logic [ROW_BITS-1:0]      tbl_row;
  logic                     act_en, pre_en, prea_en, load_en, viol;
  logic                     unused_addr_bits;

  logic                  out_valid_q, out_valid_d;
  logic [PADDR_BITS-1:0] out_addr_q, out_addr_d;
  logic                  out_is_write_q, out_is_write_d;
  logic                  err_pulse_q;
  logic [7:0]            err_count_q, err_count_d;

  assign bank             = bank_idx(bg_in, ba_in);
  assign cmd_ready        = !out_valid_q || out_ready;
  assign accept           = cmd_valid && cmd_ready;
  assign unused_addr_bits = ^addr_in;

  always_comb begin
    act_en  = 1'b0;
    pre_en  = 1'b0;
    prea_en = 1'b0;
    load_en = 1'b0;
    viol    = 1'b0;
    if (accept) begin
      case (cmd)
        CMD_NOP:  ;
        CMD_ACT:  if (tbl_open) viol = 1'b1; else act_en = 1'b1;
        CMD_RD,
        CMD_WR:   if (tbl_open) load_en = 1'b1; else viol = 1'b1;
        CMD_PRE:  pre_en = 1'b1;
        CMD_PREA: prea_en = 1'b1;
        default:  viol = 1'b1;
      endcase
    end
  end

  bank_row_table #(
    .ROW_BITS(ROW_BITS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bank),
    .rd_open_o  (tbl_open),
    .rd_row_o   (tbl_row),
    .wr_en_i    (act_en),
    .wr_idx_i   (bank),
    .wr_row_i   (addr_in[ROW_BITS-1:0]),
    .close_en_i (pre_en),
    .close_idx_i(bank),
    .close_all_i(prea_en)
  );

  // A new column command reloads the register in the same cycle the old result drains.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_is_write_d = out_is_write_q;
    if (load_en) begin
      out_valid_d = 1'b1;
      out_addr_d  = '0;
      out_addr_d[COL_BITS-1:0]                    = addr_in[COL_BITS-1:0];
      out_addr_d[COL_BITS +: BANK_IDX_BITS]       = bank;
      out_addr_d[COL_BITS+BANK_IDX_BITS +: ROW_BITS] = tbl_row;
      out_is_write_d = (cmd == CMD_WR);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (viol && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_is_write_q <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_is_write_q <= out_is_write_d;
      err_pulse_q    <= viol;
      err_count_q    <= err_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_is_write = out_is_write_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_dram_addr_composer.sv
// Directed bench for dram_addr_composer with hand-computed expected addresses.
module tb_dram_addr_composer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd;
  logic [16:0] addr_in;
  logic [1:0]  bg_in, ba_in;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_addr;
  logic        out_is_write;
  logic        err_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5;

  dram_addr_composer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .addr_in     (addr_in),
    .bg_in       (bg_in),
    .ba_in       (ba_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_is_write(out_is_write),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [1:0] bg, input logic [1:0] ba, input logic [16:0] a);
    cmd = c; bg_in = bg; ba_in = ba; addr_in = a; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd = NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    cmd = NOP; addr_in = '0; bg_in = '0; ba_in = '0; cmd_valid = 1'b0; out_ready = 1'b1;
    #2;
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_addr", 32'(out_addr), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    // 1: basic ACT then RD
    send(ACT, 2'd1, 2'd2, 17'h0A5);
    check("t1_act_noerr", 32'(err_pulse), 0);
    check("t1_act_noout", 32'(out_valid), 0);
    send(RD, 2'd1, 2'd2, 17'h003);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_addr", 32'(out_addr), 32'h0A563);
    check("t1_iswr", 32'(out_is_write), 0);
    check("t1_noerr", 32'(err_pulse), 0);
    tick();
    check("t1_drain", 32'(out_valid), 0);

    // 2: RD to closed bank
    do_reset();
    send(RD, 2'd0, 2'd0, 17'h000);
    check("t2_noout", 32'(out_valid), 0);
    check("t2_pulse", 32'(err_pulse), 1);
    check("t2_count", 32'(err_count), 1);
    tick();
    check("t2_pulse_once", 32'(err_pulse), 0);

    // 3: double ACT keeps first row; upper addr bits ignored
    do_reset();
    send(ACT, 2'd1, 2'd1, 17'h1FF10);
    send(ACT, 2'd1, 2'd1, 17'h020);
    check("t3_dup_pulse", 32'(err_pulse), 1);
    send(WR, 2'd1, 2'd1, 17'h00F);
    check("t3_count", 32'(err_count), 1);
    check("t3_valid", 32'(out_valid), 1);
    check("t3_addr", 32'(out_addr), 32'h0105F);
    check("t3_iswr", 32'(out_is_write), 1);

    // 4: PREA closes everything; PRE to closed bank is legal
    do_reset();
    send(ACT, 2'd0, 2'd0, 17'h001);
    send(ACT, 2'd3, 2'd3, 17'h002);
    send(PRE, 2'd2, 2'd0, 17'h000);
    check("t4_pre_closed_ok", 32'(err_pulse), 0);
    send(PREA, 2'd0, 2'd0, 17'h000);
    send(RD, 2'd0, 2'd0, 17'h000);
    check("t4_rd0_err", 32'(err_pulse), 1);
    send(RD, 2'd3, 2'd3, 17'h000);
    check("t4_rd15_err", 32'(err_pulse), 1);
    check("t4_count", 32'(err_count), 2);
    check("t4_noout", 32'(out_valid), 0);
    send(3'd6, 2'd0, 2'd0, 17'h000);
    check("t4_code6_err", 32'(err_pulse), 1);
    send(3'd7, 2'd0, 2'd0, 17'h000);
    check("t4_code7_count", 32'(err_count), 4);

    // 5: backpressure and back-to-back results
    do_reset();
    send(ACT, 2'd0, 2'd3, 17'h044);
    out_ready = 1'b0;
    send(RD, 2'd0, 2'd3, 17'h001);
    check("t5_valid", 32'(out_valid), 1);
    check("t5_addr", 32'(out_addr), 32'h04431);
    check("t5_ready_low", 32'(cmd_ready), 0);
    cmd = WR; bg_in = 2'd0; ba_in = 2'd3; addr_in = 17'h002; cmd_valid = 1'b1;
    tick();
    check("t5_hold_addr", 32'(out_addr), 32'h04431);
    check("t5_hold_iswr", 32'(out_is_write), 0);
    check("t5_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("t5_b2b_valid", 32'(out_valid), 1);
    check("t5_b2b_addr", 32'(out_addr), 32'h04432);
    check("t5_b2b_iswr", 32'(out_is_write), 1);
    send(RD, 2'd0, 2'd3, 17'h007);
    check("t5_b2b2_addr", 32'(out_addr), 32'h04437);
    check("t5_b2b2_iswr", 32'(out_is_write), 0);
    tick();
    check("t5_drain", 32'(out_valid), 0);

    // 6: saturation, then reset with pending output
    do_reset();
    for (int i = 0; i < 300; i++) send(RD, 2'd0, 2'd0, 17'h000);
    check("t6_saturate", 32'(err_count), 32'hFF);
    send(ACT, 2'd0, 2'd1, 17'h033);
    out_ready = 1'b0;
    send(RD, 2'd0, 2'd1, 17'h004);
    check("t6_pending", 32'(out_valid), 1);
    check("t6_count_held", 32'(err_count), 32'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_count", 32'(err_count), 0);
    out_ready = 1'b1;
    send(RD, 2'd0, 2'd1, 17'h004);
    check("t6_bank_closed", 32'(err_pulse), 1);
    check("t6_no_out", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
